// File: rtl/display_pkg.sv
// Shared display-path definitions: default digit width, the decoder blank code,
// the scan state type and a constant-evaluable ceiling log2.
package display_pkg;

    localparam int DEFAULT_DIGIT_W = 4;
    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_scan_mux_if.sv
// Bank inputs and scanned-digit outputs between the clock core and the
// 7-segment decoder path.
interface digit_scan_mux_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = display_pkg::DEFAULT_DIGIT_W
);

    logic                          en;
    logic                          sel24;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits_24;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits_12;
    logic [DIGIT_W-1:0]            digit_out;
    logic [NUM_DIGITS-1:0]         digit_en;
    logic                          blank;
    logic                          frame_done;

    modport master (
        output en, sel24, digits_24, digits_12,
        input  digit_out, digit_en, blank, frame_done
    );

    modport slave (
        input  en, sel24, digits_24, digits_12,
        output digit_out, digit_en, blank, frame_done
    );

endinterface

// File: rtl/digit_scan_mux_prescaler.sv
// Digit hold-time counter: counts 0..PRESCALE-1 and flags the terminal count.
// With PRESCALE=1 the counter stays at zero and tick is permanently high.
module scan_prescaler
    import display_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [CW-1:0] TERMINAL = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == TERMINAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed digit selector: latches one bank per scan frame and drives
// one digit at a time with a one-hot anode select and leading-zero blanking.
module digit_scan_mux
    import display_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int DIGIT_W       = DEFAULT_DIGIT_W,
    parameter int PRESCALE      = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    digit_scan_mux_if.slave bus
);

    localparam int IW = (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS);

    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] bank_t;

    scan_state_t           state_q, state_d;
    logic [IW-1:0]         idx;
    bank_t                 shadow;
    bank_t                 next_bank;
    logic [DIGIT_W-1:0]    digit_q;
    logic [NUM_DIGITS-1:0] digit_en_q;
    logic                  blank_q;
    logic                  done_q;
    logic                  clr;
    logic                  tick;
    logic                  last;
    logic                  blank_cond;

    assign next_bank = bus.sel24 ? bank_t'(bus.digits_24) : bank_t'(bus.digits_12);
    assign last      = (idx == IW'(NUM_DIGITS - 1));
    assign clr       = !bus.en || (state_q == ST_IDLE);

    scan_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        if (!bus.en) begin
            state_d = ST_IDLE;
        end else begin
            state_d = ST_SCAN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Blank only when this digit and every more significant one are zero; digit 0 always shows.
    always_comb begin
        blank_cond = BLANK_LEADING && (idx != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx) && shadow[i] != '0) begin
                blank_cond = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            shadow     <= '0;
            digit_q    <= '0;
            digit_en_q <= '0;
            blank_q    <= 1'b1;
            done_q     <= 1'b0;
        end else if (!bus.en) begin
            idx        <= '0;
            digit_en_q <= '0;
            blank_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            digit_q    <= shadow[idx];
            digit_en_q <= NUM_DIGITS'(1) << idx;
            blank_q    <= blank_cond;
            done_q     <= 1'b0;
            if (state_q == ST_IDLE) begin
                shadow <= next_bank;
                idx    <= '0;
            end else if (tick) begin
                if (last) begin
                    // Bank is resampled only at the wrap so a frame never mixes sources.
                    idx    <= '0;
                    shadow <= next_bank;
                    done_q <= 1'b1;
                end else begin
                    idx <= idx + IW'(1);
                end
            end
        end
    end

    assign bus.digit_out  = digit_q;
    assign bus.digit_en   = digit_en_q;
    assign bus.blank      = blank_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Drives a PRESCALE=4 and a PRESCALE=1 scanner with identical inputs and compares
// both against a frame-position reference model every cycle.
module tb_digit_scan_mux;

    localparam int N = 4;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    digit_scan_mux_if #(.NUM_DIGITS(N), .DIGIT_W(W)) bus_p4 ();
    digit_scan_mux_if #(.NUM_DIGITS(N), .DIGIT_W(W)) bus_p1 ();

    digit_scan_mux #(
        .NUM_DIGITS(N), .DIGIT_W(W), .PRESCALE(4), .BLANK_LEADING(1'b1)
    ) dut_p4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_p4.slave)
    );

    digit_scan_mux #(
        .NUM_DIGITS(N), .DIGIT_W(W), .PRESCALE(1), .BLANK_LEADING(1'b1)
    ) dut_p1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_p1.slave)
    );

    int total = 0;
    int bad   = 0;

    logic        en_v;
    logic        sel_v;
    logic [15:0] d24_v;
    logic [15:0] d12_v;

    // Model: position within the frame in cycles; the shown digit is position / PRESCALE.
    int           m_presc [2] = '{4, 1};
    bit           m_run   [2];
    int           m_pos   [2];
    int           m_sh    [2][N];
    logic [W-1:0] m_dout  [2];
    logic [N-1:0] m_den   [2];
    logic         m_blank [2];
    logic         m_fd    [2];

    function automatic int bank_digit(input logic [15:0] bank, input int i);
        logic [15:0] shifted;
        shifted = bank >> (i * W);
        return int'(shifted[W-1:0]);
    endfunction

    function automatic logic model_blank(input int k, input int pos_idx);
        int top;
        top = -1;
        for (int j = 0; j < N; j++) begin
            if (m_sh[k][j] != 0) top = j;
        end
        return (pos_idx > 0) && (pos_idx > top);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k]   = 1'b0;
            m_pos[k]   = 0;
            m_dout[k]  = '0;
            m_den[k]   = '0;
            m_blank[k] = 1'b1;
            m_fd[k]    = 1'b0;
            for (int j = 0; j < N; j++) m_sh[k][j] = 0;
        end
    endtask

    task automatic model_load(input int k);
        for (int j = 0; j < N; j++) begin
            m_sh[k][j] = sel_v ? bank_digit(d24_v, j) : bank_digit(d12_v, j);
        end
    endtask

    task automatic model_edge();
        int p;
        int cur;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            p   = m_presc[k];
            cur = m_pos[k] / p;
            if (!en_v) begin
                m_run[k]   = 1'b0;
                m_pos[k]   = 0;
                m_den[k]   = '0;
                m_blank[k] = 1'b1;
                m_fd[k]    = 1'b0;
            end else begin
                m_dout[k]  = W'(m_sh[k][cur]);
                m_den[k]   = N'(1) << cur;
                m_blank[k] = model_blank(k, cur);
                m_fd[k]    = 1'b0;
                if (!m_run[k]) begin
                    model_load(k);
                    m_run[k] = 1'b1;
                    m_pos[k] = 0;
                end else if (m_pos[k] == N * p - 1) begin
                    model_load(k);
                    m_pos[k] = 0;
                    m_fd[k]  = 1'b1;
                end else begin
                    m_pos[k]++;
                end
            end
        end
    endtask

    task automatic check_one(input int k, input logic [W-1:0] dout, input logic [N-1:0] den,
                             input logic blk, input logic fd);
        string pfx;
        pfx = (k == 0) ? "p4" : "p1";
        total++;
        assert (dout === m_dout[k]) else begin
            bad++;
            $error("[TB] FAIL %s_digit_out observed=%0h expected=%0h", pfx, dout, m_dout[k]);
        end
        total++;
        assert (den === m_den[k]) else begin
            bad++;
            $error("[TB] FAIL %s_digit_en observed=%b expected=%b", pfx, den, m_den[k]);
        end
        total++;
        assert (blk === m_blank[k]) else begin
            bad++;
            $error("[TB] FAIL %s_blank observed=%b expected=%b", pfx, blk, m_blank[k]);
        end
        total++;
        assert (fd === m_fd[k]) else begin
            bad++;
            $error("[TB] FAIL %s_frame_done observed=%b expected=%b", pfx, fd, m_fd[k]);
        end
    endtask

    task automatic check_output();
        check_one(0, bus_p4.digit_out, bus_p4.digit_en, bus_p4.blank, bus_p4.frame_done);
        check_one(1, bus_p1.digit_out, bus_p1.digit_en, bus_p1.blank, bus_p1.frame_done);
    endtask

    task automatic apply_stimulus(input logic e, input logic s, input logic [15:0] a,
                                  input logic [15:0] b);
        en_v  = e;
        sel_v = s;
        d24_v = a;
        d12_v = b;
        bus_p4.en = e;  bus_p4.sel24 = s;  bus_p4.digits_24 = a;  bus_p4.digits_12 = b;
        bus_p1.en = e;  bus_p1.sel24 = s;  bus_p1.digits_24 = a;  bus_p1.digits_12 = b;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_output();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Advances until the PRESCALE=4 model is running on the requested digit, at most 40 cycles.
    task automatic run_to_digit(input int d);
        for (int i = 0; i < 40 && !(m_run[0] && (m_pos[0] / 4 == d)); i++) cycle();
    endtask

    function automatic logic [15:0] random_bank();
        logic [15:0] v;
        v = 16'($urandom);
        for (int j = 0; j < N; j++) begin
            if ($urandom_range(1, 0) == 0) v[j*W +: W] = '0;
        end
        return v;
    endfunction

    initial begin
        rst_n = 1'b1;
        apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_output();
        run_cycles(2);
        rst_n = 1'b1;
        run_cycles(2);

        $display("[TB] 24 h bank 2359");
        apply_stimulus(1'b1, 1'b1, 16'h2359, 16'h0000);
        run_cycles(40);

        $display("[TB] 12 h bank 0105 with leading-zero blanking");
        apply_stimulus(1'b1, 1'b0, 16'h2359, 16'h0105);
        run_cycles(40);

        $display("[TB] sel24 toggled mid-frame");
        apply_stimulus(1'b1, 1'b1, 16'h2359, 16'h0105);
        run_cycles(20);
        run_to_digit(2);
        apply_stimulus(1'b1, 1'b0, 16'h2359, 16'h0105);
        run_cycles(24);

        $display("[TB] all-zero bank");
        apply_stimulus(1'b1, 1'b1, 16'h0000, 16'h0105);
        run_cycles(40);

        $display("[TB] enable dropped at digit 1");
        run_to_digit(1);
        apply_stimulus(1'b0, 1'b1, 16'h0000, 16'h0105);
        run_cycles(3);
        apply_stimulus(1'b1, 1'b1, 16'h4817, 16'h0105);
        run_cycles(24);

        $display("[TB] asynchronous reset mid-digit");
        run_to_digit(2);
        cycle();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_output();
        run_cycles(2);
        rst_n = 1'b1;
        run_cycles(30);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 300; i++) begin
            apply_stimulus(($urandom_range(19, 0) != 0), 1'($urandom), random_bank(), random_bank());
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
